fraction_divider4: RTL and testbench
====================================

# fraction_divider4

Sequential signed-fraction divider, the inverse companion of the 4-bit fraction multiplier. It takes a 7-bit two's-complement 1.6 dividend (the multiplier's product format) and a 4-bit two's-complement 1.3 divisor (the multiplier's operand format). It returns a 4-bit 1.3 quotient, truncated toward zero, using a magnitude restoring shift-subtract loop. A St/Done handshake matches the multiplier's, and an overflow flag covers unrepresentable results.

## Interface
- No parameters; widths fixed at 4-bit operand / 7-bit dividend.
- CLK  input  1  rising-edge clock
- RSTn  input  1  asynchronous active-low reset
- St  input  1  start; sampled only in IDLE
- Dividend  input  7  two's-complement 1.6 fraction (value = Dividend/64)
- Divisor  input  4  two's-complement 1.3 fraction (value = Divisor/8)
- Quotient  output  4  two's-complement 1.3 fraction result, registered
- V  output  1  overflow / divide-by-zero flag, registered
- Busy  output  1  high from CHK through SIGN
- Done  output  1  high for exactly one cycle in DONE

## Operation
- States: IDLE, CHK, DIV, SIGN, DONE.
- **IDLE**
  - On an edge with St=1: capture D = |Dividend| (7-bit unsigned, 0..64) and d = |Divisor| (4-bit unsigned, 0..8).
  - On the same edge, capture sign bit s = Dividend[6] XOR Divisor[3], clear the partial remainder and the quotient shift register, then go to CHK.
  - With St=0: stay in IDLE.
- **CHK** (one cycle)
  - If d==0 or D >= 8*d: set V=1, Quotient=0000, go to DONE.
  - Otherwise set V=0, load the 3-bit iteration counter with 2, go to DIV.
  - Dividend 1000000 (-1.0) always overflows by this rule; -1.0 is never produced as a quotient.
- **DIV** (exactly 3 cycles, counter 2..0)
  - Each cycle, for i = counter: trial = R - (d << i), where R starts at D.
  - If trial >= 0: R = trial and quotient bit i = 1. Otherwise R is unchanged and bit i = 0.
  - Leave DIV when the counter reaches 0.
  - Result: magnitude q = floor(D/d), 3 bits, 0..7. The remainder is internal only.
- **SIGN** (one cycle)
  - Quotient = (s && q!=0) ? -{0,q} : {0,q}, in 4-bit two's complement.
  - Zero quotient is always 0000; a negative zero never appears.
- **DONE** (one cycle): Done=1, then go to IDLE unconditionally.
- Quotient and V hold their values until the next CHK/SIGN writes them.
- St while not in IDLE is ignored; this includes St held high through DONE.
- St held continuously high restarts the divider on the edge after DONE, since IDLE samples it.
- Dividend and Divisor are don't-care except on the accepting edge.
- Width rules:
  - Trial subtraction is 8 bits signed.
  - d << 2 needs 6 bits; 8*d needs 7 bits and the D >= 8*d compare is 8 bits.
  - No wrap-around is allowed anywhere.

## Timing
- Reset (RSTn=0, any state, asynchronous): state=IDLE, Quotient=0000, V=0, Busy=0, Done=0, internal registers cleared.
- Reset mid-operation aborts the division with no Done. The first St after RSTn deasserts starts a clean division.
- Let k be the accepting edge. Normal path:
  - CHK during cycle k+1, DIV during k+2..k+4, SIGN during k+5, DONE during k+6.
  - Done is high 6 cycles after acceptance.
- Overflow path: CHK during k+1, DONE during k+2, Done high 2 cycles after acceptance.
- Quotient/V are valid on and after the cycle Done is high. They change only at the CHK (overflow) or SIGN edges.
- Busy=1 exactly during CHK, DIV and SIGN. Busy=0 during IDLE and DONE.
- Minimum start-to-start spacing: 7 cycles normal, 3 cycles overflow.

## Test plan
- Reset: assert RSTn=0 mid-DIV.
  - Required: Quotient=0000, V=0, Busy=0, Done=0 immediately.
  - No Done pulse follows; the next St completes normally.
- Dividend 0010000 (+0.25), Divisor 0100 (+0.5).
  - Required: Quotient 0100 (+0.5), V=0.
  - Done exactly 6 cycles after the accepting edge, single-cycle.
- Dividend 1110000 (-0.25), Divisor 0110 (+0.75).
  - Required: Quotient 1110 (-0.25, truncated toward zero), V=0.
- Overflow, Dividend 0100000 (+0.5) / 0100 (+0.5): V=1, Quotient 0000, Done 2 cycles after acceptance.
- Overflow, any dividend / Divisor 0000: V=1, Quotient 0000, Done 2 cycles after acceptance.
- Multiplier round trip: Dividend 1011100 (-36/64, product of 0110 × 1010), Divisor 1010 (-0.75).
  - Required: Quotient 0110 (+0.75), V=0.
- St held high for 20 cycles with fixed operands.
  - Required: operations back-to-back every 7 cycles.
  - Operand changes during Busy do not affect the result.

Source files
------------

// File: rtl/fraction_divider4.sv
`default_nettype none
// ============================================================================
// fraction_divider4 : sequential 1.6 / 1.3 signed-fraction divider giving a
//                     1.3 quotient truncated toward zero, with overflow flag.
// Revision 1.0
// ============================================================================
module fraction_divider4 (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       St,
  input  logic [6:0] Dividend,
  input  logic [3:0] Divisor,
  output logic [3:0] Quotient,
  output logic       V,
  output logic       Busy,
  output logic       Done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CHK  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_next;

  logic [6:0] r_dvd_mag;
  logic [3:0] r_dvs_mag;
  logic       r_sign;
  logic [6:0] r_rem;
  logic [2:0] r_q;
  logic [2:0] r_cnt;
  logic [3:0] r_quot;
  logic       r_v;

  logic [6:0] w_dvd_abs;
  logic [3:0] w_dvs_abs;
  logic       w_ovf;
  logic [7:0] w_shifted;
  logic [7:0] w_trial;
  logic [3:0] w_qmag;

  // -64 and -8 map onto 1000000 / 1000, which read correctly as unsigned 64 / 8
  assign w_dvd_abs = Dividend[6] ? (~Dividend + 7'd1) : Dividend;
  assign w_dvs_abs = Divisor[3]  ? (~Divisor  + 4'd1) : Divisor;

  assign w_ovf     = (r_dvs_mag == 4'd0) ||
                     ({1'b0, r_dvd_mag} >= {1'b0, r_dvs_mag, 3'b000});
  assign w_shifted = {4'b0000, r_dvs_mag} << r_cnt;
  assign w_trial   = {1'b0, r_rem} - w_shifted;
  assign w_qmag    = {1'b0, r_q};

  assign Quotient  = r_quot;
  assign V         = r_v;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (St) w_next = S_CHK;
      S_CHK:   w_next = w_ovf ? S_DONE : S_DIV;
      S_DIV:   if (r_cnt == 3'd0) w_next = S_SIGN;
      S_SIGN:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (r_state == S_CHK) || (r_state == S_DIV) || (r_state == S_SIGN);
    Done = (r_state == S_DONE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dvd_mag <= 7'd0;
      r_dvs_mag <= 4'd0;
      r_sign    <= 1'b0;
      r_rem     <= 7'd0;
      r_q       <= 3'd0;
      r_cnt     <= 3'd0;
      r_quot    <= 4'd0;
      r_v       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (St) begin
          r_dvd_mag <= w_dvd_abs;
          r_dvs_mag <= w_dvs_abs;
          r_sign    <= Dividend[6] ^ Divisor[3];
          r_rem     <= 7'd0;
          r_q       <= 3'd0;
        end
        S_CHK: begin
          if (w_ovf) begin
            r_v    <= 1'b1;
            r_quot <= 4'd0;
          end else begin
            r_v   <= 1'b0;
            r_cnt <= 3'd2;
            r_rem <= r_dvd_mag;
          end
        end
        S_DIV: begin
          // quotient bits arrive MSB first, so a left shift places bit i
          if (!w_trial[7]) r_rem <= w_trial[6:0];
          r_q <= {r_q[1:0], ~w_trial[7]};
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
        S_SIGN: r_quot <= (r_sign && (r_q != 3'd0)) ? (~w_qmag + 4'd1) : w_qmag;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fraction_divider4.sv
`default_nettype none
// Bench for fraction_divider4: directed table, random vects vs. arithmetic model,
// reset abort and St-held back-to-back sequences.
module tb_fraction_divider4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st;
  logic [6:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic       v;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  fraction_divider4 dut (
    .CLK(clk), .RSTn(rst_n), .St(st), .Dividend(dividend), .Divisor(divisor),
    .Quotient(quotient), .V(v), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic       v;
    string      name;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Quotient code = trunc(Dividend/Divisor) since (a/64)/(b/8)*8 = a/b.
  task automatic model(input logic [6:0] a, input logic [3:0] b,
                       output logic [3:0] q, output logic ov);
    int va, vb, qi;
    va = int'($signed(a));
    vb = int'($signed(b));
    if (vb == 0 || ((va < 0 ? -va : va) >= 8 * (vb < 0 ? -vb : vb))) begin
      ov = 1'b1;
      q  = 4'd0;
    end else begin
      ov = 1'b0;
      qi = va / vb;
      q  = 4'(qi);
    end
  endtask

  task automatic run_op(input logic [6:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic ev, input string name);
    int lat;
    bit bad;
    lat = ev ? 2 : 6;
    bad = 1'b0;
    @(negedge clk);
    st = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n == 1) begin
        st = 1'b0;
        dividend = 7'($urandom);
        divisor  = 4'($urandom);
      end
      if (n < lat && (!busy || done)) bad = 1'b1;
    end
    chk({name, "_done_latency"}, {7'd0, done}, 8'd1);
    chk({name, "_quotient"}, {4'd0, quotient}, {4'd0, eq});
    chk({name, "_v"}, {7'd0, v}, {7'd0, ev});
    chk({name, "_busy_profile"}, {7'd0, bad}, 8'd0);
    @(negedge clk);
    chk({name, "_done_single"}, {6'd0, done, busy}, 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ra;
    logic [3:0] rb, mq;
    logic       mv;
    int         done_at[$];
    bit         seen;

    tbl[0]  = '{7'b0010000, 4'b0100, 4'b0100, 1'b0, "q25_by_half"};
    tbl[1]  = '{7'b1110000, 4'b0110, 4'b1110, 1'b0, "neg25_by_75"};
    tbl[2]  = '{7'b0100000, 4'b0100, 4'b0000, 1'b1, "ovf_half_half"};
    tbl[3]  = '{7'b0010011, 4'b0000, 4'b0000, 1'b1, "div_by_zero"};
    tbl[4]  = '{7'b1011100, 4'b1010, 4'b0110, 1'b0, "mul_roundtrip"};
    tbl[5]  = '{7'b1000000, 4'b1000, 4'b0000, 1'b1, "neg_one_ovf"};
    tbl[6]  = '{7'b0000111, 4'b1000, 4'b0000, 1'b0, "no_neg_zero"};
    tbl[7]  = '{7'b0111111, 4'b1000, 4'b1001, 1'b0, "max_neg_q"};
    tbl[8]  = '{7'b0000000, 4'b0011, 4'b0000, 1'b0, "zero_dividend"};
    tbl[9]  = '{7'b0011000, 4'b0011, 4'b0000, 1'b1, "ovf_boundary"};
    tbl[10] = '{7'b1101001, 4'b0011, 4'b1001, 1'b0, "under_boundary"};

    rst_n = 1'b0; st = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_quotient", {4'd0, quotient}, 8'd0);
    chk("reset_v", {7'd0, v}, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].v, tbl[i].name);

    for (int i = 0; i < 40; i++) begin
      ra = 7'($urandom);
      rb = 4'($urandom);
      model(ra, rb, mq, mv);
      run_op(ra, rb, mq, mv, "random");
    end

    // Abort mid-DIV: last result (0110) must vanish immediately.
    run_op(7'b1011100, 4'b1010, 4'b0110, 1'b0, "pre_abort");
    @(negedge clk);
    st = 1'b1; dividend = 7'b0010000; divisor = 4'b0100;
    @(posedge clk);
    repeat (3) @(negedge clk);
    st = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_quotient", {4'd0, quotient}, 8'd0);
    chk("abort_v", {7'd0, v}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", {7'd0, seen}, 8'd0);
    run_op(7'b1110000, 4'b0110, 4'b1110, 1'b0, "post_abort");

    // St held high: restarts every 7 cycles, operands scrambled while busy.
    @(negedge clk);
    st = 1'b1; dividend = 7'b0010000; divisor = 4'b0100;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(n);
        chk("hold_quotient", {4'd0, quotient}, 8'd4);
      end
      if (busy) begin
        dividend = 7'($urandom);
        divisor  = 4'($urandom);
      end else begin
        dividend = 7'b0010000;
        divisor  = 4'b0100;
      end
    end
    st = 1'b0;
    chk("hold_done_count", 8'(done_at.size()), 8'd3);
    for (int i = 0; i < done_at.size() && i < 3; i++)
      chk("hold_done_cycle", 8'(done_at[i]), 8'(6 + 7 * i));
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
